// File: rtl/writeback_unit_pkg.sv
// writeback_unit_pkg
//   Shared widths, defaults and state encoding for the writeback stage.
//   WB_DSIZE   : default data width
//   WB_ASIZE   : default register address width
//   WB_TIMEOUT : default number of LOAD_WAIT cycles before a load is abandoned
package writeback_unit_pkg;

  localparam int WB_DSIZE   = 16;
  localparam int WB_ASIZE   = 4;
  localparam int WB_TIMEOUT = 15;

  typedef enum logic {
    WB_IDLE  = 1'b0,
    WB_LWAIT = 1'b1
  } wb_state_t;

  // A write is dropped only when the zero register is read-only and targeted.
  function automatic logic wb_write_allowed(input logic zero_reg_ro, input logic rd_is_zero);
    return !(zero_reg_ro && rd_is_zero);
  endfunction

endpackage

// File: rtl/writeback_unit_timer.sv
// wb_timeout_timer
//   8-bit up-counter measuring how long a load has been outstanding.
//   clk    : clock, rising edge
//   rst    : asynchronous reset, active-low
//   clear  : restart the count at 0 (has priority over enable)
//   enable : advance the count by one
//   expire : count has reached TIMEOUT-1 (combinational)
module wb_timeout_timer #(
  parameter int TIMEOUT = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam logic [7:0] LAST = 8'(TIMEOUT - 1);

  logic [7:0] count;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  assign expire = (count == LAST);

endmodule

// File: rtl/writeback_unit.sv
// writeback_unit
//   Final pipeline stage: retires ALU results and load data into the register
//   file write port. All write-port outputs are registered.
//   clk, rst                      : clock (rising edge), async reset (active-low)
//   in_valid / in_ready           : MEM-stage handshake (in_ready = state is IDLE)
//   in_regwrite, in_load, in_rd,
//   in_alu                        : instruction fields
//   dmem_rvalid, dmem_rdata       : load response (one-cycle pulse)
//   wen, waddr, wdata             : registered regfile write port
//   load_err                      : one-cycle pulse when a load times out
//   retire_cnt                    : number of cycles with wen=1, modulo 2^16
//
//   state     | meaning
//   ----------+-----------------------------------------------
//   WB_IDLE   | ready for a new instruction
//   WB_LWAIT  | load accepted, waiting for dmem_rvalid or timeout
module writeback_unit
  import writeback_unit_pkg::*;
#(
  parameter int DSIZE       = WB_DSIZE,
  parameter int ASIZE       = WB_ASIZE,
  parameter int TIMEOUT     = WB_TIMEOUT,
  parameter int ZERO_REG_RO = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic             in_regwrite,
  input  logic             in_load,
  input  logic [ASIZE-1:0] in_rd,
  input  logic [DSIZE-1:0] in_alu,
  input  logic             dmem_rvalid,
  input  logic [DSIZE-1:0] dmem_rdata,
  output logic             wen,
  output logic [ASIZE-1:0] waddr,
  output logic [DSIZE-1:0] wdata,
  output logic             load_err,
  output logic [15:0]      retire_cnt
);

  localparam logic ZRO = (ZERO_REG_RO != 0);

  wb_state_t        state;
  logic [ASIZE-1:0] rd_held;
  logic             accept;
  logic             alu_accept;
  logic             load_accept;
  logic             timer_en;
  logic             expire;

  assign in_ready    = (state == WB_IDLE);
  assign accept      = in_valid & in_ready;
  assign alu_accept  = accept & in_regwrite & ~in_load;
  // A load that does not write a register has nothing to wait for.
  assign load_accept = accept & in_regwrite & in_load;
  assign timer_en    = (state == WB_LWAIT) & ~dmem_rvalid;

  wb_timeout_timer #(.TIMEOUT(TIMEOUT)) u_timer (
    .clk    (clk),
    .rst    (rst),
    .clear  (load_accept),
    .enable (timer_en),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= WB_IDLE;
      rd_held    <= '0;
      wen        <= 1'b0;
      waddr      <= '0;
      wdata      <= '0;
      load_err   <= 1'b0;
      retire_cnt <= 16'd0;
    end else begin
      wen        <= 1'b0;
      load_err   <= 1'b0;
      // Counts the registered wen, so the count trails the write by a cycle.
      retire_cnt <= retire_cnt + 16'(wen);
      case (state)
        WB_IDLE: begin
          if (alu_accept) begin
            if (wb_write_allowed(ZRO, in_rd == '0)) begin
              wen   <= 1'b1;
              waddr <= in_rd;
              wdata <= in_alu;
            end
          end else if (load_accept) begin
            rd_held <= in_rd;
            state   <= WB_LWAIT;
          end
        end
        WB_LWAIT: begin
          // Response arriving in the expiry cycle still wins over the timeout.
          if (dmem_rvalid) begin
            if (wb_write_allowed(ZRO, rd_held == '0)) begin
              wen   <= 1'b1;
              waddr <= rd_held;
              wdata <= dmem_rdata;
            end
            state <= WB_IDLE;
          end else if (expire) begin
            load_err <= 1'b1;
            state    <= WB_IDLE;
          end
        end
        default: state <= WB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_writeback_unit.sv
// tb_writeback_unit
//   Directed test of writeback_unit. u_dut uses default parameters (TIMEOUT=15,
//   writable r0); u_zro has a read-only zero register and TIMEOUT=4 and also
//   carries the retire counter wrap test.
module tb_writeback_unit;

  logic        clk;
  logic        rst;

  logic        in_valid, in_ready, in_regwrite, in_load;
  logic [3:0]  in_rd;
  logic [15:0] in_alu;
  logic        dmem_rvalid;
  logic [15:0] dmem_rdata;
  logic        wen, load_err;
  logic [3:0]  waddr;
  logic [15:0] wdata, retire_cnt;

  logic        z_valid, z_ready, z_regwrite, z_load;
  logic [3:0]  z_rd;
  logic [15:0] z_alu;
  logic        z_rvalid;
  logic [15:0] z_rdata;
  logic        z_wen, z_load_err;
  logic [3:0]  z_waddr;
  logic [15:0] z_wdata, z_retire;

  int checks = 0;
  int errors = 0;

  writeback_unit u_dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_regwrite(in_regwrite), .in_load(in_load),
    .in_rd(in_rd), .in_alu(in_alu),
    .dmem_rvalid(dmem_rvalid), .dmem_rdata(dmem_rdata),
    .wen(wen), .waddr(waddr), .wdata(wdata),
    .load_err(load_err), .retire_cnt(retire_cnt)
  );

  writeback_unit #(.TIMEOUT(4), .ZERO_REG_RO(1)) u_zro (
    .clk(clk), .rst(rst),
    .in_valid(z_valid), .in_ready(z_ready),
    .in_regwrite(z_regwrite), .in_load(z_load),
    .in_rd(z_rd), .in_alu(z_alu),
    .dmem_rvalid(z_rvalid), .dmem_rdata(z_rdata),
    .wen(z_wen), .waddr(z_waddr), .wdata(z_wdata),
    .load_err(z_load_err), .retire_cnt(z_retire)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic rw, input logic ld,
                       input logic [3:0] rd, input logic [15:0] alu);
    in_valid = v; in_regwrite = rw; in_load = ld; in_rd = rd; in_alu = alu;
  endtask

  initial begin
    rst = 1'b0;
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    dmem_rvalid = 1'b0; dmem_rdata = 16'h0;
    z_valid = 1'b0; z_regwrite = 1'b0; z_load = 1'b0; z_rd = 4'd0; z_alu = 16'h0;
    z_rvalid = 1'b0; z_rdata = 16'h0;

    // Reset state
    tick(); tick();
    chk("rst_wen", wen, 0);
    chk("rst_waddr", waddr, 0);
    chk("rst_wdata", wdata, 0);
    chk("rst_load_err", load_err, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_ready", in_ready, 1);
    rst = 1'b1;
    tick();

    // 1. Back-to-back ALU writes
    drive(1'b1, 1'b1, 1'b0, 4'd3, 16'h1234);
    chk("alu_ready", in_ready, 1);
    tick();
    chk("alu0_wen", wen, 1);
    chk("alu0_waddr", waddr, 3);
    chk("alu0_wdata", wdata, 16'h1234);
    drive(1'b1, 1'b1, 1'b0, 4'd5, 16'h00FF);
    tick();
    chk("alu1_wen", wen, 1);
    chk("alu1_waddr", waddr, 5);
    chk("alu1_wdata", wdata, 16'h00FF);
    chk("alu1_retire", retire_cnt, 1);
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    tick();
    chk("alu_bubble_wen", wen, 0);
    chk("alu_retire", retire_cnt, 2);
    tick();
    chk("alu_hold_waddr", waddr, 5);
    chk("alu_hold_wdata", wdata, 16'h00FF);
    chk("alu_hold_retire", retire_cnt, 2);

    // 2. Load answered 4 cycles after accept
    drive(1'b1, 1'b1, 1'b1, 4'd7, 16'hAAAA);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 0; i < 4; i++) begin
      chk("ld_wait_ready", in_ready, 0);
      chk("ld_wait_wen", wen, 0);
      if (i == 3) begin
        dmem_rvalid = 1'b1; dmem_rdata = 16'hBEEF;
      end
      tick();
    end
    dmem_rvalid = 1'b0; dmem_rdata = 16'h0;
    chk("ld_wen", wen, 1);
    chk("ld_waddr", waddr, 7);
    chk("ld_wdata", wdata, 16'hBEEF);
    chk("ld_ready", in_ready, 1);
    chk("ld_err", load_err, 0);
    tick();
    chk("ld_retire", retire_cnt, 3);
    chk("ld_wen_after", wen, 0);

    // 3. Timeout with no response
    drive(1'b1, 1'b1, 1'b1, 4'd2, 16'h5A5A);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 1; i <= 15; i++) begin
      tick();
      chk($sformatf("to_err_%0d", i), load_err, (i == 15));
      chk($sformatf("to_ready_%0d", i), in_ready, (i == 15));
      chk("to_wen", wen, 0);
    end
    tick();
    chk("to_err_pulse", load_err, 0);
    chk("to_retire", retire_cnt, 3);
    chk("to_waddr_hold", waddr, 7);

    // 4. Response in the expiry cycle wins
    drive(1'b1, 1'b1, 1'b1, 4'd9, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    for (int i = 1; i <= 14; i++) tick();
    chk("race_pre_ready", in_ready, 0);
    dmem_rvalid = 1'b1; dmem_rdata = 16'hC0DE;
    tick();
    dmem_rvalid = 1'b0;
    chk("race_wen", wen, 1);
    chk("race_waddr", waddr, 9);
    chk("race_wdata", wdata, 16'hC0DE);
    chk("race_err", load_err, 0);
    chk("race_ready", in_ready, 1);

    // Stale response while IDLE
    dmem_rvalid = 1'b1; dmem_rdata = 16'hDEAD;
    tick();
    dmem_rvalid = 1'b0;
    chk("stale_wen", wen, 0);
    chk("stale_err", load_err, 0);
    chk("stale_wdata", wdata, 16'hC0DE);
    chk("stale_retire", retire_cnt, 4);

    // Non-writing load and non-writing ALU op: no wait, no write
    drive(1'b1, 1'b0, 1'b1, 4'd4, 16'h4444);
    tick();
    chk("nw_load_ready", in_ready, 1);
    chk("nw_load_wen", wen, 0);
    drive(1'b1, 1'b0, 1'b0, 4'd6, 16'h6666);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    chk("nw_alu_wen", wen, 0);
    tick();
    chk("nw_retire", retire_cnt, 4);

    // 5. Async reset during LOAD_WAIT
    drive(1'b1, 1'b1, 1'b1, 4'd6, 16'h0);
    tick();
    drive(1'b0, 1'b0, 1'b0, 4'd0, 16'h0);
    tick(); tick();
    chk("ar_wait_ready", in_ready, 0);
    #2;
    rst = 1'b0;
    #1;
    chk("ar_wen", wen, 0);
    chk("ar_retire", retire_cnt, 0);
    chk("ar_ready", in_ready, 1);
    chk("ar_waddr", waddr, 0);
    #1;
    rst = 1'b1;
    tick();
    dmem_rvalid = 1'b1; dmem_rdata = 16'h1111;
    tick();
    dmem_rvalid = 1'b0;
    chk("ar_post_wen", wen, 0);
    tick();
    chk("ar_post_retire", retire_cnt, 0);

    // 6. Read-only zero register
    z_valid = 1'b1; z_regwrite = 1'b1; z_load = 1'b0; z_rd = 4'd0; z_alu = 16'h5555;
    tick();
    z_valid = 1'b0;
    chk("z0_wen", z_wen, 0);
    chk("z0_waddr", z_waddr, 0);
    tick();
    chk("z0_retire", z_retire, 0);
    z_valid = 1'b1; z_load = 1'b1; z_rd = 4'd0;
    tick();
    z_valid = 1'b0; z_load = 1'b0;
    chk("z0_ld_ready", z_ready, 0);
    z_rvalid = 1'b1; z_rdata = 16'h7777;
    tick();
    z_rvalid = 1'b0;
    chk("z0_ld_wen", z_wen, 0);
    chk("z0_ld_ready_after", z_ready, 1);
    chk("z0_ld_err", z_load_err, 0);

    // Retire counter wrap: 65535 writes then one more
    z_valid = 1'b1; z_regwrite = 1'b1; z_load = 1'b0; z_rd = 4'd1; z_alu = 16'hABCD;
    tick();
    chk("wrap_first_wen", z_wen, 1);
    chk("wrap_first_waddr", z_waddr, 1);
    repeat (65534) tick();
    z_valid = 1'b0;
    tick();
    chk("wrap_ffff", z_retire, 16'hFFFF);
    chk("wrap_idle_wen", z_wen, 0);
    z_valid = 1'b1;
    tick();
    z_valid = 1'b0;
    tick();
    chk("wrap_zero", z_retire, 16'h0000);
    chk("wrap_dut_retire", retire_cnt, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
